// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch request generator with one-entry redirect buffer
module pc_fetch #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = {ADDR_W{1'b0}},
    parameter logic [31:0]        EXC_VEC    = 32'h0000_0180,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rest_n,
    input  logic              stall,
    input  logic              zero,
    input  logic              great,
    input  logic [15:0]       im1,
    input  logic [25:0]       im2,
    input  logic [3:0]        pc_op,
    input  logic [ADDR_W-1:0] j_reg,
    input  logic [ADDR_W-1:0] cop_addr,
    input  logic              exc,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rt_addr,
    output logic              redirect,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [3:0] PC_OP_BZ    = 4'd1;
    localparam logic [3:0] PC_OP_BNZ   = 4'd2;
    localparam logic [3:0] PC_OP_BG    = 4'd3;
    localparam logic [3:0] PC_OP_BNG   = 4'd4;
    localparam logic [3:0] PC_OP_BGZ   = 4'd5;
    localparam logic [3:0] PC_OP_BNGNZ = 4'd6;
    localparam logic [3:0] PC_OP_J     = 4'd7;
    localparam logic [3:0] PC_OP_JR    = 4'd8;
    localparam logic [3:0] PC_OP_COP0  = 4'd9;

    logic              accept;
    logic              taken;
    logic              is_redir;
    logic              pend_v;
    logic [ADDR_W-1:0] pend_t;
    logic [ADDR_W-1:0] seq_t;
    logic [ADDR_W-1:0] exc_t;
    logic [ADDR_W-1:0] br_t;
    logic [ADDR_W-1:0] j_t;
    logic [ADDR_W-1:0] target;

    // target selection; exception outranks branches, which outrank jumps
    always_comb begin
        accept   = if_valid & if_ready & ~stall;
        seq_t    = addr + ADDR_W'(4);
        exc_t    = ADDR_W'(EXC_VEC);
        br_t     = addr + ADDR_W'($signed({im1, 2'b00}));
        j_t      = (addr & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({im2, 2'b00});
        taken    = (pc_op == PC_OP_BZ    &  zero) |
                   (pc_op == PC_OP_BNZ   & ~zero) |
                   (pc_op == PC_OP_BG    &  great) |
                   (pc_op == PC_OP_BNG   & ~great) |
                   (pc_op == PC_OP_BGZ   & (zero | great)) |
                   (pc_op == PC_OP_BNGNZ & ~zero & ~great);
        is_redir = exc | taken | pc_op == PC_OP_J | pc_op == PC_OP_JR | pc_op == PC_OP_COP0;
        target   = exc ? exc_t : taken ? br_t : pc_op == PC_OP_J ? j_t :
                   pc_op == PC_OP_JR ? j_reg : cop_addr;
    end

    // PC advance on accept, pending redirect capture, and saturating stall counter
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            if_valid  <= 1'b0;
            addr      <= RESET_ADDR;
            rt_addr   <= '0;
            redirect  <= 1'b0;
            stall_cnt <= '0;
            pend_v    <= 1'b0;
            pend_t    <= '0;
        end else begin
            if_valid <= 1'b1;
            redirect <= accept & (is_redir | pend_v);
            if (accept) begin
                addr    <= (pend_v & ~exc) ? pend_t : is_redir ? target : seq_t;
                rt_addr <= seq_t;
                pend_v  <= 1'b0;
            end else if (is_redir & (~pend_v | exc)) begin
                pend_v <= 1'b1;
                pend_t <= target;
            end
            if (if_valid & ~accept & ~&stall_cnt)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed-vector self-checking bench for pc_fetch
module tb_pc_fetch;
    localparam logic [3:0] NOP = 4'd0, BZ = 4'd1, BNZ = 4'd2, BG = 4'd3,
                           J = 4'd7, JR = 4'd8, COP0 = 4'd9;

    logic        clk = 1'b0;
    logic        rest_n, stall, zero, great, exc, if_ready;
    logic [15:0] im1;
    logic [25:0] im2;
    logic [3:0]  pc_op;
    logic [31:0] j_reg, cop_addr;
    logic        if_valid, redirect;
    logic [31:0] addr, rt_addr;
    logic [3:0]  stall_cnt;
    int          n_chk = 0;
    int          n_pass = 0;

    pc_fetch #(.CNT_W(4)) dut (
        .clk(clk), .rest_n(rest_n), .stall(stall), .zero(zero), .great(great),
        .im1(im1), .im2(im2), .pc_op(pc_op), .j_reg(j_reg), .cop_addr(cop_addr),
        .exc(exc), .if_ready(if_ready), .if_valid(if_valid), .addr(addr),
        .rt_addr(rt_addr), .redirect(redirect), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rest_n = 1'b0; stall = 1'b0; zero = 1'b0; great = 1'b0; exc = 1'b0;
        if_ready = 1'b1; im1 = '0; im2 = '0; pc_op = NOP; j_reg = '0; cop_addr = '0;
        #12;
        check("rst_addr", addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_rt", rt_addr, 32'h0);
        check("rst_redir", {31'b0, redirect}, 32'h0);
        check("rst_cnt", {28'b0, stall_cnt}, 32'h0);
        rest_n = 1'b1;
        step();
        check("t1_valid", {31'b0, if_valid}, 32'h1);
        check("t1_addr0", addr, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t1_addr", addr, 32'(4 * i));
            check("t1_rt", rt_addr, 32'(4 * i));
            check("t1_redir", {31'b0, redirect}, 32'h0);
        end
        pc_op = JR; j_reg = 32'h100;
        step();
        check("jr_addr", addr, 32'h100);
        check("jr_rt", rt_addr, 32'h14);
        check("jr_redir", {31'b0, redirect}, 32'h1);
        pc_op = BZ; zero = 1'b1; im1 = 16'hFFFC;
        step();
        check("t2_addr", addr, 32'hF0);
        check("t2_redir", {31'b0, redirect}, 32'h1);
        pc_op = NOP; zero = 1'b0;
        step();
        check("t2_seq", addr, 32'hF4);
        check("t2_pulse", {31'b0, redirect}, 32'h0);
        pc_op = JR; j_reg = 32'h200;
        step();
        check("t3_pre", addr, 32'h200);
        pc_op = J; im1 = 16'h1234; im2 = 26'h40; if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold", addr, 32'h200);
            check("t3_redir", {31'b0, redirect}, 32'h0);
        end
        check("t3_cnt", {28'b0, stall_cnt}, 32'h3);
        pc_op = NOP; if_ready = 1'b1;
        step();
        check("t3_addr", addr, 32'h100);
        check("t3_redir2", {31'b0, redirect}, 32'h1);
        check("t3_cnt2", {28'b0, stall_cnt}, 32'h3);
        pc_op = JR; j_reg = 32'h400; if_ready = 1'b0;
        step();
        pc_op = NOP; exc = 1'b1;
        step();
        check("t4_hold", addr, 32'h100);
        exc = 1'b0; if_ready = 1'b1;
        step();
        check("t4_addr", addr, 32'h180);
        check("t4_cnt", {28'b0, stall_cnt}, 32'h5);
        pc_op = JR; j_reg = 32'h400; if_ready = 1'b0;
        step();
        pc_op = COP0; cop_addr = 32'h800;
        step();
        pc_op = NOP; if_ready = 1'b1;
        step();
        check("t5_addr", addr, 32'h400);
        check("t5_redir", {31'b0, redirect}, 32'h1);
        step();
        check("t5_seq", addr, 32'h404);
        stall = 1'b1;
        step();
        check("stall_hold", addr, 32'h404);
        check("stall_cnt", {28'b0, stall_cnt}, 32'h8);
        stall = 1'b0; pc_op = BNZ; zero = 1'b1;
        step();
        check("bnz_nt", addr, 32'h408);
        check("bnz_redir", {31'b0, redirect}, 32'h0);
        pc_op = BG; zero = 1'b0; great = 1'b1; im1 = 16'h0004;
        step();
        check("bg_t", addr, 32'h418);
        pc_op = NOP; great = 1'b0; if_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("sat_cnt", {28'b0, stall_cnt}, 32'hF);
        check("sat_hold", addr, 32'h418);
        if_ready = 1'b1; pc_op = JR; j_reg = 32'hFFFF_FFFC;
        step();
        check("t6_pre", addr, 32'hFFFF_FFFC);
        pc_op = NOP;
        step();
        check("t6_wrap", addr, 32'h0);
        check("t6_rt", rt_addr, 32'h0);
        pc_op = JR; j_reg = 32'h400; if_ready = 1'b0;
        step();
        #2 rest_n = 1'b0;
        #1;
        check("t6_addr", addr, 32'h0);
        check("t6_valid", {31'b0, if_valid}, 32'h0);
        check("t6_cnt", {28'b0, stall_cnt}, 32'h0);
        #1 rest_n = 1'b1; pc_op = NOP; if_ready = 1'b1;
        step();
        check("t6_rel", addr, 32'h0);
        check("t6_valid2", {31'b0, if_valid}, 32'h1);
        step();
        check("t6_nopend", addr, 32'h4);
        check("t6_redir", {31'b0, redirect}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
